// File: rtl/lib_switchblock_pkg.sv
// Shared definitions for the DEM switching-block library: sample width,
// accumulator width, merge-monitor FSM states and the clamp helper.
package lib_switchblock_pkg;

    localparam int WIDTH = 5;
    localparam int ACC_W = WIDTH + 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } merge_state_t;

    // Clamp a signed value into the two's-complement range of a w-bit word.
    function automatic logic signed [31:0] sat_to_width(input logic signed [31:0] val,
                                                        input int w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (w - 1));
        if (val > hi) begin
            return hi;
        end else if (val < lo) begin
            return lo;
        end else begin
            return val;
        end
    endfunction

endpackage

// File: rtl/dem_merge_checker.sv
// Switching-term integrator, split/bound checks, monitor FSM and error counter.
// Error counter is built only when DEM_MERGE_ERRCNT_EN is defined.
module dem_merge_checker #(
    parameter int WIDTH     = lib_switchblock_pkg::WIDTH,
    parameter int ACC_BOUND = 2,
    parameter int ERR_CNT_W = 8
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  clr_i,
    input  logic                  vld_p1,
    input  logic signed [WIDTH:0] diff_p1,
    output logic signed [WIDTH+1:0] acc_o,
    output logic                  err_o,
    output logic [ERR_CNT_W-1:0]  err_cnt_o
);
    import lib_switchblock_pkg::*;

    localparam int AW = WIDTH + 2;

    merge_state_t             state;
    merge_state_t             state_nxt;
    logic signed [31:0]       diff_ext;
    logic signed [31:0]       acc_sum;
    logic signed [AW-1:0]     acc_nxt;
    logic                     split_err;
    logic                     bound_err;
    logic                     sample_err;

    // A legal split differs by at most one unit; the running sum must stay inside +/-ACC_BOUND.
    always_comb begin
        diff_ext   = 32'(diff_p1);
        acc_sum    = 32'(acc_o) + diff_ext;
        acc_nxt    = AW'(sat_to_width(acc_sum, AW));
        split_err  = (diff_ext > 1) || (diff_ext < -1);
        bound_err  = (32'(acc_nxt) > ACC_BOUND) || (32'(acc_nxt) < -ACC_BOUND);
        sample_err = vld_p1 && (split_err || bound_err);
    end

    // Stage 2: accumulator updates on the same edge as the data outputs
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            acc_o <= '0;
        end else if (clr_i) begin
            acc_o <= '0;
        end else if (vld_p1) begin
            acc_o <= acc_nxt;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        err_o     = 1'b0;
        case (state)
            IDLE: begin
                if (vld_p1) begin
                    state_nxt = sample_err ? FAULT : TRACK;
                end
            end
            TRACK: begin
                if (sample_err) begin
                    state_nxt = FAULT;
                end
            end
            FAULT: begin
                err_o = 1'b1;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (clr_i) begin
            state_nxt = IDLE;
        end
    end

`ifdef DEM_MERGE_ERRCNT_EN
    logic [ERR_CNT_W-1:0] err_cnt;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            err_cnt <= '0;
        end else if (clr_i) begin
            err_cnt <= '0;
        end else if (sample_err && !(&err_cnt)) begin
            err_cnt <= err_cnt + ERR_CNT_W'(1);
        end
    end

    assign err_cnt_o = err_cnt;
`else
    assign err_cnt_o = '0;
`endif

endmodule

// File: rtl/dem_merge_block.sv
// Receive-side merge of a DEM switching block: rebuilds the code (x1+x2), recovers
// the switching term (x1-x2) and monitors its integral. Optional: DEM_MERGE_ERRCNT_EN.
module dem_merge_block #(
    parameter int WIDTH     = lib_switchblock_pkg::WIDTH,
    parameter int ACC_BOUND = 2,
    parameter int ERR_CNT_W = 8
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    clr_i,
    input  logic                    valid_i,
    input  logic signed [WIDTH-1:0] x_out1_i,
    input  logic signed [WIDTH-1:0] x_out2_i,
    output logic                    valid_o,
    output logic signed [WIDTH-1:0] x_rec_o,
    output logic signed [WIDTH-1:0] s_o,
    output logic signed [WIDTH+1:0] acc_o,
    output logic                    sat_o,
    output logic                    err_o,
    output logic [ERR_CNT_W-1:0]    err_cnt_o
);
    import lib_switchblock_pkg::*;

    localparam int W1 = WIDTH + 1;

    logic                    vld_p1;
    logic signed [W1-1:0]    sum_p1;
    logic signed [W1-1:0]    diff_p1;
    logic signed [31:0]      sum_ext;
    logic signed [WIDTH-1:0] x_rec_nxt;
    logic signed [WIDTH-1:0] s_nxt;
    logic                    sat_nxt;

    // Stage 1: one guard bit keeps sum and difference exact
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            vld_p1  <= 1'b0;
            sum_p1  <= '0;
            diff_p1 <= '0;
        end else if (clr_i) begin
            vld_p1  <= 1'b0;
        end else begin
            vld_p1 <= valid_i;
            if (valid_i) begin
                sum_p1  <= W1'(x_out1_i) + W1'(x_out2_i);
                diff_p1 <= W1'(x_out1_i) - W1'(x_out2_i);
            end
        end
    end

    always_comb begin
        sum_ext   = 32'(sum_p1);
        x_rec_nxt = WIDTH'(sat_to_width(sum_ext, WIDTH));
        sat_nxt   = (sat_to_width(sum_ext, WIDTH) != sum_ext);
        s_nxt     = WIDTH'(sat_to_width(32'(diff_p1), WIDTH));
    end

    // Stage 2: clamped outputs; they hold between valid samples and across a clear
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            valid_o <= 1'b0;
            x_rec_o <= '0;
            s_o     <= '0;
            sat_o   <= 1'b0;
        end else if (clr_i) begin
            valid_o <= 1'b0;
        end else begin
            valid_o <= vld_p1;
            if (vld_p1) begin
                x_rec_o <= x_rec_nxt;
                s_o     <= s_nxt;
                sat_o   <= sat_nxt;
            end
        end
    end

    dem_merge_checker #(
        .WIDTH     (WIDTH),
        .ACC_BOUND (ACC_BOUND),
        .ERR_CNT_W (ERR_CNT_W)
    ) u_checker (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .clr_i     (clr_i),
        .vld_p1    (vld_p1),
        .diff_p1   (diff_p1),
        .acc_o     (acc_o),
        .err_o     (err_o),
        .err_cnt_o (err_cnt_o)
    );

endmodule

// File: doc/dem_merge_block.md
# dem_merge_block

- Receive side of the DEM-DAC switching-block split, inverse of `SwitchingBlock`.
- Takes one block's output pair (x_out1, x_out2) and rebuilds the original code as their sum.
- Recovers the switching term as their difference and integrates it to monitor first-order mismatch shaping.
- Sits after the switching tree: DEM output-path monitor and self-check reference for tree benches.

## Interface
Parameters:
- WIDTH, default lib_switchblock_pkg::WIDTH (5): signed sample width, same as SwitchingBlock.
- ACC_BOUND, default 2: legal magnitude of the switching-term running sum.
- ERR_CNT_W, default 8: error counter width.

Ports:
- clk_i  input  1  single clock; all state on rising edge
- reset_i  input  1  asynchronous, active-low reset (asserted when 0)
- clr_i  input  1  synchronous clear of accumulator, FSM, counter, pipeline valids
- valid_i  input  1  input pair valid this cycle
- x_out1_i  input  WIDTH signed  first branch from switching block
- x_out2_i  input  WIDTH signed  second branch from switching block
- valid_o  output  1  outputs valid
- x_rec_o  output  WIDTH signed  reconstructed code, saturated
- s_o  output  WIDTH signed  recovered switching term x_out1_i - x_out2_i, saturated
- acc_o  output  WIDTH+2 signed  running sum of switching terms
- sat_o  output  1  x_rec_o saturated for this sample
- err_o  output  1  high while FSM in FAULT
- err_cnt_o  output  ERR_CNT_W  count of erroneous samples, saturating

## Operation
- Stage 1, when valid_i: register sum = x1+x2 and diff = x1-x2, both WIDTH+1 bits, sign-extended; v1 <= valid_i.
- Stage 2, when v1:
  - x_rec_o = sum clamped to [-2^(WIDTH-1), 2^(WIDTH-1)-1]; sat_o = clamp applied.
  - s_o = diff clamped the same way.
  - acc <= acc + diff, WIDTH+2 bits, wrap not permitted; acc_o shows new value.
- Per-sample errors:
  - split_err: |diff| > 1, since a legal split differs by at most one unit.
  - bound_err: |new acc| > ACC_BOUND.
  - Saturation alone is not an error.
- FSM merge_state_t:
  - IDLE -> TRACK on first v1.
  - TRACK -> FAULT on split_err or bound_err.
  - FAULT stays until clr_i or reset.
  - clr_i from any state -> IDLE.
- err_cnt_o +1 per erroneous sample, holds at all-ones.
- Outputs and acc hold between valid samples.

## Timing
- Latency: valid_o and data 2 cycles after valid_i sampled; throughput one sample per cycle, no backpressure.
- Reset (reset_i=0): asynchronous clear; all outputs 0, acc 0, FSM IDLE, v1/valid_o 0.
- Reset mid-stream: in-flight samples dropped; first output after release is 2 cycles after next valid_i.
- clr_i with valid_i same cycle: clear wins, that sample and the in-flight sample discarded; valid_o low next cycle.
- Error on the sample entering FAULT: err_o high with that sample's valid_o (same edge as data).
- Counter at all-ones plus new error: stays all-ones.

## Configuration
- DEM_MERGE_ERRCNT_EN defined: error counter present as above.
- DEM_MERGE_ERRCNT_EN not defined:
  - counter not built; err_cnt_o tied 0.
  - FSM, err_o and all data paths unchanged.

## Structure
- lib_switchblock_pkg additions:
  - ACC_W = WIDTH+2.
  - merge_state_t enum {IDLE, TRACK, FAULT}.
  - sat_to_width function for clamping.
- Sub-module dem_merge_checker: owns accumulator, bound/split checks, FSM and counter.
- Top level holds stage-1 registers and the clamps.

## Test plan
- (3,4) then (2,2) then (5,4), one per cycle -> x_rec 7,4,9; s -1,0,+1; acc -1,-1,0; valid_o 2 cycles after each; err_o 0.
- (6,2) -> s 4, split_err; err_o 1 with that sample; err_cnt 1; FAULT held; clr_i -> err_o 0, acc 0, IDLE.
- Three samples s=+1 with ACC_BOUND=2 -> acc 1,2,3; err_o rises on third.
- (10,10) -> x_rec 15, sat_o 1, s 0, err_o 0.
- reset_i low for one cycle mid-stream with valids in pipeline -> all outputs 0 immediately; no stale valid_o after release.
- clr_i and valid_i together -> sample dropped, valid_o low, acc 0; with DEM_MERGE_ERRCNT_EN off, err_cnt_o 0 throughout.
